note_player: RTL and testbench

//  Square-wave tone sequencer for the buzzer; consumes the divided game clock (clk2Mhz).

---
 rtl/note_player_pkg.sv | 16 +
 rtl/note_player_tick_prescaler.sv | 22 ++
 rtl/note_player.sv | 138 +++++++++++++
 tb/tb_note_player.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared state encoding and default parameters for the note_player buzzer sequencer.
package note_player_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int DEF_CLK_HZ  = 2_000_000;
    localparam int DEF_TICK_HZ = 1000;
    localparam int DEF_PER_W   = 16;
    localparam int DEF_LEN_W   = 12;
    localparam int DEF_GAP_TK  = 10;

endpackage

// File: rtl/note_player_tick_prescaler.sv
// Divides the block clock by DIV and emits a one-cycle tick; clr restarts the count at zero.
module tick_prescaler #(
    parameter int DIV = 2000
) (
    input  logic clk2Mhz,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk2Mhz) begin
        if (rst || clr || tick) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/note_player.sv
// Square-wave tone sequencer: plays one note (half-period, duration) per valid/ready handshake.
// Optional silent gap after each note when NOTE_GAP_EN is defined.
module note_player
    import note_player_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ,
    parameter int PER_W   = DEF_PER_W,
    parameter int LEN_W   = DEF_LEN_W
`ifdef NOTE_GAP_EN
    ,
    parameter int GAP_TK  = DEF_GAP_TK
`endif
) (
    input  logic             clk2Mhz,
    input  logic             rst,
    input  logic             note_valid,
    input  logic [PER_W-1:0] note_period,
    input  logic [LEN_W-1:0] note_len,
    output logic             note_ready,
    input  logic             abort,
    output logic             buzz,
    output logic             playing,
    output logic             done
);

    state_t           state, state_n;
    logic [PER_W-1:0] per_q, per_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [PER_W-1:0] half_cnt, half_n;
    logic [LEN_W-1:0] tick_cnt, tick_n;
    logic             buzz_n, done_n;
    logic             tick, play_end;

    // Prescaler is held at zero while idle, so the accept edge starts a clean duration count.
    tick_prescaler #(.DIV(CLK_HZ / TICK_HZ)) u_presc (
        .clk2Mhz (clk2Mhz),
        .rst     (rst),
        .clr     ((state == S_IDLE) || play_end),
        .tick    (tick)
    );

    assign play_end = (state == S_PLAY) &&
                      ((len_q == '0) || (tick && (tick_cnt == len_q - 1'b1)));

    always_comb begin
        state_n = state;
        per_n   = per_q;
        len_n   = len_q;
        half_n  = half_cnt;
        tick_n  = tick_cnt;
        buzz_n  = buzz;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                buzz_n = 1'b0;
                half_n = '0;
                tick_n = '0;
                if (note_valid) begin
                    per_n   = note_period;
                    len_n   = note_len;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (abort) begin
                    state_n = S_IDLE;
                    buzz_n  = 1'b0;
                end else if (play_end) begin
                    buzz_n = 1'b0;
                    half_n = '0;
                    tick_n = '0;
`ifdef NOTE_GAP_EN
                    state_n = S_GAP;
`else
                    state_n = S_IDLE;
                    done_n  = 1'b1;
`endif
                end else begin
                    if (tick) tick_n = tick_cnt + 1'b1;
                    // A zero half-period is a rest: counters idle, buzz stays low.
                    if (per_q != '0) begin
                        if (half_cnt == per_q - 1'b1) begin
                            half_n = '0;
                            buzz_n = ~buzz;
                        end else begin
                            half_n = half_cnt + 1'b1;
                        end
                    end
                end
            end
`ifdef NOTE_GAP_EN
            S_GAP: begin
                buzz_n = 1'b0;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (tick) begin
                    if (tick_cnt == LEN_W'(GAP_TK - 1)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                buzz_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk2Mhz) begin
        if (rst) begin
            state      <= S_IDLE;
            per_q      <= '0;
            len_q      <= '0;
            half_cnt   <= '0;
            tick_cnt   <= '0;
            buzz       <= 1'b0;
            done       <= 1'b0;
            playing    <= 1'b0;
            note_ready <= 1'b1;
        end else begin
            state      <= state_n;
            per_q      <= per_n;
            len_q      <= len_n;
            half_cnt   <= half_n;
            tick_cnt   <= tick_n;
            buzz       <= buzz_n;
            done       <= done_n;
            playing    <= (state_n != S_IDLE);
            note_ready <= (state_n == S_IDLE);
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player at CLK_HZ=20, TICK_HZ=1: vector table, corner sequences and random notes.
module tb_note_player;

    localparam int DIV = 20;
`ifdef NOTE_GAP_EN
    localparam int GAP_CYC = 2 * DIV;
`else
    localparam int GAP_CYC = 0;
`endif

    logic        clk2Mhz = 1'b0;
    logic        rst = 1'b1;
    logic        note_valid = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] note_period = '0;
    logic [11:0] note_len = '0;
    logic        note_ready, buzz, playing, done;

    int checks = 0;
    int failures = 0;

    always #5 clk2Mhz = ~clk2Mhz;

    note_player #(
        .CLK_HZ (20),
        .TICK_HZ(1),
        .PER_W  (16),
        .LEN_W  (12)
`ifdef NOTE_GAP_EN
        ,
        .GAP_TK (2)
`endif
    ) dut (
        .clk2Mhz    (clk2Mhz),
        .rst        (rst),
        .note_valid (note_valid),
        .note_period(note_period),
        .note_len   (note_len),
        .note_ready (note_ready),
        .abort      (abort),
        .buzz       (buzz),
        .playing    (playing),
        .done       (done)
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input logic with_abort);
        abort = with_abort;
        for (int i = 0; i < n; i++) begin
            @(negedge clk2Mhz);
            chk("idle_buzz", i, buzz, 0);
            chk("idle_playing", i, playing, 0);
            chk("idle_ready", i, note_ready, 1);
            chk("idle_done", i, done, 0);
        end
        abort = 1'b0;
    endtask

    // Reference: k counts cycles after the accept edge. The note ends at edge e (duration,
    // plus gap, or the abort edge); buzz after edge k is the parity of completed half-periods.
    // Called at a negedge while idle; returns at the negedge following edge e.
    task automatic run_note(input int p, input int l, input int ab, input logic hold,
                            output int play_cyc, output int rises, output int dones);
        int dur, total, e, t, exp_b, prev_b;
        logic aborted;
        dur     = (l == 0) ? 1 : l * DIV;
        total   = dur + GAP_CYC;
        aborted = (ab > 0) && (ab <= total);
        e       = aborted ? ab : total;
        t       = (dur < e) ? dur : e;
        note_valid  = 1'b1;
        note_period = 16'(p);
        note_len    = 12'(l);
        chk("ready_at_req", -1, note_ready, 1);
        play_cyc = 0; rises = 0; dones = 0; prev_b = 0;
        for (int k = 0; k <= e; k++) begin
            @(negedge clk2Mhz);
            abort = 1'b0;
            if (k == 0) begin
                note_valid  = hold;
                note_period = 16'($urandom_range(0, 65535));
                note_len    = 12'($urandom_range(0, 4095));
            end
            exp_b = 0;
            if (p != 0 && k < t) exp_b = (k / p) % 2;
            chk("buzz", k, buzz, exp_b);
            chk("playing", k, playing, (k < e) ? 1 : 0);
            chk("ready", k, note_ready, (k >= e) ? 1 : 0);
            chk("done", k, done, (k == e && !aborted) ? 1 : 0);
            play_cyc += playing ? 1 : 0;
            rises    += (buzz && prev_b == 0) ? 1 : 0;
            prev_b    = buzz;
            dones    += done ? 1 : 0;
            if (k + 1 == ab) abort = 1'b1;
        end
        if (!hold) note_valid = 1'b0;
    endtask

    typedef struct {
        int p;
        int l;
        int ab;
        int exp_len;
        int exp_rises;
        int exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pc, rs, dn, exp_play;

        vecs[0] = '{p: 5,  l: 3, ab: 0,  exp_len: 60, exp_rises: 6,  exp_done: 1};
        vecs[1] = '{p: 0,  l: 2, ab: 0,  exp_len: 40, exp_rises: 0,  exp_done: 1};
        vecs[2] = '{p: 1,  l: 1, ab: 0,  exp_len: 20, exp_rises: 10, exp_done: 1};
        vecs[3] = '{p: 4,  l: 4, ab: 25, exp_len: 25, exp_rises: 3,  exp_done: 0};
        vecs[4] = '{p: 3,  l: 0, ab: 0,  exp_len: 1,  exp_rises: 0,  exp_done: 1};
        vecs[5] = '{p: 7,  l: 2, ab: 0,  exp_len: 40, exp_rises: 3,  exp_done: 1};
        vecs[6] = '{p: 20, l: 1, ab: 0,  exp_len: 20, exp_rises: 0,  exp_done: 1};
        vecs[7] = '{p: 2,  l: 2, ab: 3,  exp_len: 3,  exp_rises: 1,  exp_done: 0};

        // Power-on reset.
        repeat (3) @(negedge clk2Mhz);
        chk("rst_buzz", 0, buzz, 0);
        chk("rst_playing", 0, playing, 0);
        chk("rst_ready", 0, note_ready, 1);
        chk("rst_done", 0, done, 0);
        rst = 1'b0;
        idle_cycles(2, 1'b0);

        // Abort while idle is ignored.
        idle_cycles(4, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_note(vecs[i].p, vecs[i].l, vecs[i].ab, 1'b0, pc, rs, dn);
            exp_play = (vecs[i].ab != 0) ? vecs[i].exp_len : vecs[i].exp_len + GAP_CYC;
            chk("vec_play_cycles", i, pc, exp_play);
            chk("vec_rises", i, rs, vecs[i].exp_rises);
            chk("vec_dones", i, dn, vecs[i].exp_done);
            idle_cycles(2, 1'b0);
        end

        // Request held through a note: second note starts exactly once, right after IDLE.
        run_note(5, 1, 0, 1'b1, pc, rs, dn);
        run_note(3, 1, 0, 1'b0, pc, rs, dn);
        chk("hold_second_dones", 0, dn, 1);
        idle_cycles(30, 1'b0);

        // Abort and note_valid together in IDLE: note accepted.
        abort = 1'b1;
        run_note(4, 1, 0, 1'b0, pc, rs, dn);
        chk("abort_valid_idle_dones", 0, dn, 1);
        idle_cycles(2, 1'b0);

        // Reset in the middle of a note.
        note_valid = 1'b1; note_period = 16'd5; note_len = 12'd3;
        @(negedge clk2Mhz);
        note_valid = 1'b0;
        repeat (29) @(negedge clk2Mhz);
        chk("pre_rst_playing", 0, playing, 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2Mhz);
            chk("midrst_buzz", i, buzz, 0);
            chk("midrst_playing", i, playing, 0);
            chk("midrst_ready", i, note_ready, 1);
            chk("midrst_done", i, done, 0);
        end
        rst = 1'b0;
        idle_cycles(80, 1'b0);

        // Random notes against the reference, some aborted, some back to back.
        for (int n = 0; n < 25; n++) begin
            int p, l, ab, tot;
            p   = $urandom_range(0, 9);
            l   = $urandom_range(0, 3);
            tot = ((l == 0) ? 1 : l * DIV) + GAP_CYC;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot + 1) : 0;
            run_note(p, l, ab, 1'b0, pc, rs, dn);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2), 1'b0);
        end
        abort = 1'b0;
        idle_cycles(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
